// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and types for the D/E hazard controller
package pipe_pkg;

   localparam int RF_IDX_W = 5;

   localparam logic [2:0] WB_NONE = 3'd0;
   localparam logic [2:0] WB_ALU  = 3'd1;
   localparam logic [2:0] WB_MEM  = 3'd2;
   localparam logic [2:0] WB_PC4  = 3'd3;
   localparam logic [2:0] WB_CSR  = 3'd4;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_M  = 2'd1;
   localparam logic [1:0] FWD_W  = 2'd2;

   typedef enum logic [1:0] {
      RUN,
      LDUSE,
      CSR_DRAIN,
      MEM_FREEZE
   } hz_state_t;

   typedef struct packed {
      logic                valid;
      logic [RF_IDX_W-1:0] rd;
      logic [2:0]          wb_src;
   } sb_entry_t;

   // An entry only counts as a producer if it really writes a non-zero register.
   function automatic logic sb_writes(input sb_entry_t e);
      return e.valid && (e.wb_src != WB_NONE) && (e.rd != '0);
   endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - M/W stage scoreboard and execute operand forwarding selects
module hz_scoreboard
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             advance,
   input  logic             ex_valid,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [2:0]       ex_wb_src,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   output logic             m_valid,
   output logic             w_valid,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2
);

   sb_entry_t m_q;
   sb_entry_t w_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_q <= '{valid: 1'b0, rd: '0, wb_src: WB_NONE};
         w_q <= '{valid: 1'b0, rd: '0, wb_src: WB_NONE};
      end else if (advance) begin
         m_q <= '{valid: ex_valid, rd: ex_rd, wb_src: ex_wb_src};
         w_q <= m_q;
      end
   end

   // A load in M has no data yet, so only W may supply a loaded value.
   function automatic logic [1:0] fwd_of(input logic [REG_W-1:0] rs);
      if (sb_writes(m_q) && (rs == m_q.rd) && (m_q.wb_src != WB_MEM))
         return FWD_M;
      else if (sb_writes(w_q) && (rs == w_q.rd))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

   assign fwd_sel1 = fwd_of(ex_rs1);
   assign fwd_sel2 = fwd_of(ex_rs2);
   assign m_valid  = m_q.valid;
   assign w_valid  = w_q.valid;

endmodule

// File: rtl/d_e_hazard_ctrl.sv
// rtl/d_e_hazard_ctrl.sv - stall, bubble, flush and forwarding control for the D/E register
module d_e_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int DRAIN_MAX = 3
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_rs1,
   input  logic [REG_W-1:0] dec_rs2,
   input  logic [1:0]       dec_dep,
   input  logic             dec_is_csr,
   input  logic             ex_valid,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [2:0]       ex_wb_src,
   input  logic             mem_wait,
   input  logic             branch_taken,
   output logic             stall_fd,
   output logic             stall_de,
   output logic             bubble_de,
   output logic             flush_fd,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2
);

   localparam int CNT_W = $clog2(DRAIN_MAX + 1);

   hz_state_t        state_q, state_d;
   hz_state_t        saved_q, saved_d;
   hz_state_t        eff_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic stall_fd_c, stall_de_c, bubble_de_c, flush_fd_c;
   logic m_valid, w_valid;
   logic load_use, csr_hit, pipe_empty;

   hz_scoreboard #(.REG_W(REG_W)) u_sb (
      .clk       (clk),
      .nrst      (nrst),
      .advance   (!stall_de_c && !mem_wait),
      .ex_valid  (ex_valid),
      .ex_rd     (ex_rd),
      .ex_wb_src (ex_wb_src),
      .ex_rs1    (ex_rs1),
      .ex_rs2    (ex_rs2),
      .m_valid   (m_valid),
      .w_valid   (w_valid),
      .fwd_sel1  (fwd_sel1),
      .fwd_sel2  (fwd_sel2)
   );

   assign pipe_empty = !ex_valid && !m_valid && !w_valid;
   assign load_use   = dec_valid && ex_valid && (ex_wb_src == WB_MEM) && (ex_rd != '0) &&
                       ((dec_dep[0] && (dec_rs1 == ex_rd)) || (dec_dep[1] && (dec_rs2 == ex_rd)));
   assign csr_hit    = dec_valid && dec_is_csr && !pipe_empty;

   // On the cycle mem_wait drops, behave as the state that was frozen.
   assign eff_state = (state_q == MEM_FREEZE) ? saved_q : state_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= RUN;
         saved_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      saved_d     = saved_q;
      cnt_d       = cnt_q;
      stall_fd_c  = 1'b0;
      stall_de_c  = 1'b0;
      bubble_de_c = 1'b0;
      flush_fd_c  = 1'b0;
      if (mem_wait) begin
         stall_fd_c = 1'b1;
         stall_de_c = 1'b1;
         state_d    = MEM_FREEZE;
         if (state_q != MEM_FREEZE)
            saved_d = state_q;
      end else if (branch_taken) begin
         flush_fd_c  = 1'b1;
         bubble_de_c = 1'b1;
         state_d     = RUN;
         cnt_d       = '0;
      end else begin
         state_d = RUN;
         case (eff_state)
            RUN: begin
               if (load_use) begin
                  stall_fd_c  = 1'b1;
                  bubble_de_c = 1'b1;
                  state_d     = LDUSE;
               end else if (csr_hit) begin
                  stall_fd_c  = 1'b1;
                  bubble_de_c = 1'b1;
                  cnt_d       = CNT_W'(DRAIN_MAX - 1);
                  state_d     = CSR_DRAIN;
               end
            end
            CSR_DRAIN: begin
               if (!pipe_empty && (cnt_q != '0)) begin
                  stall_fd_c  = 1'b1;
                  bubble_de_c = 1'b1;
                  cnt_d       = cnt_q - 1'b1;
                  state_d     = CSR_DRAIN;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_fd  = nrst && stall_fd_c;
   assign stall_de  = nrst && stall_de_c;
   assign bubble_de = nrst && bubble_de_c;
   assign flush_fd  = nrst && flush_fd_c;

endmodule

// File: tb/tb_d_e_hazard_ctrl.sv
// tb/tb_d_e_hazard_ctrl.sv - self-checking bench for d_e_hazard_ctrl
`timescale 1ns/1ps
module tb_d_e_hazard_ctrl;

   localparam int DRAIN_MAX = 3;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       dec_valid = 1'b0, dec_is_csr = 1'b0, ex_valid = 1'b0;
   logic [4:0] dec_rs1 = '0, dec_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
   logic [1:0] dec_dep = '0;
   logic [2:0] ex_wb_src = '0;
   logic       mem_wait = 1'b0, branch_taken = 1'b0;
   logic       stall_fd, stall_de, bubble_de, flush_fd;
   logic [1:0] fwd_sel1, fwd_sel2;

   d_e_hazard_ctrl #(.REG_W(5), .DRAIN_MAX(DRAIN_MAX)) dut (
      .clk(clk), .nrst(nrst),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_dep(dec_dep), .dec_is_csr(dec_is_csr),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wb_src(ex_wb_src),
      .mem_wait(mem_wait), .branch_taken(branch_taken),
      .stall_fd(stall_fd), .stall_de(stall_de), .bubble_de(bubble_de), .flush_fd(flush_fd),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: history of the last two instructions that left E, plus pending waits.
   // A frozen cycle is simply a cycle in which time does not move for the model.
   typedef struct { bit v; int rd; int src; } ent_t;
   ent_t hist[2];
   bit   ldu_pend, draining;
   int   drain_left;
   int   e_sfd, e_sde, e_bub, e_fl, e_f1, e_f2;
   int   o_sfd, o_sde, o_bub, o_fl, o_f1, o_f2;

   task automatic model_rst();
      for (int i = 0; i < 2; i++) hist[i] = '{0, 0, 0};
      ldu_pend = 0; draining = 0; drain_left = 0;
   endtask

   function automatic bit writes(input ent_t e);
      return e.v && e.src != 0 && e.rd != 0;
   endfunction

   function automatic int fwd_of(input int rs);
      if (writes(hist[0]) && hist[0].rd == rs && hist[0].src != 2) return 1;
      if (writes(hist[1]) && hist[1].rd == rs) return 2;
      return 0;
   endfunction

   function automatic bit lu_hit();
      return dec_valid && ex_valid && ex_wb_src == 2 && ex_rd != 0 &&
             ((dec_dep[0] && dec_rs1 == ex_rd) || (dec_dep[1] && dec_rs2 == ex_rd));
   endfunction

   function automatic bit pipe_empty();
      return !ex_valid && !hist[0].v && !hist[1].v;
   endfunction

   function automatic bit csr_wait();
      return dec_valid && dec_is_csr && !pipe_empty();
   endfunction

   task automatic model_out();
      e_sfd = 0; e_sde = 0; e_bub = 0; e_fl = 0;
      e_f1 = fwd_of(int'(ex_rs1));
      e_f2 = fwd_of(int'(ex_rs2));
      if (mem_wait) begin
         e_sfd = 1; e_sde = 1;
      end else if (branch_taken) begin
         e_fl = 1; e_bub = 1;
      end else if (ldu_pend) begin
      end else if (draining) begin
         if (!(pipe_empty() || drain_left == 0)) begin e_sfd = 1; e_bub = 1; end
      end else if (lu_hit() || csr_wait()) begin
         e_sfd = 1; e_bub = 1;
      end
   endtask

   task automatic model_adv();
      bit lu, cs, done;
      if (mem_wait) return;
      lu = lu_hit();
      cs = csr_wait();
      done = pipe_empty() || drain_left == 0;
      hist[1] = hist[0];
      hist[0] = '{ex_valid, int'(ex_rd), int'(ex_wb_src)};
      if (branch_taken) begin
         ldu_pend = 0; draining = 0; drain_left = 0;
      end else if (ldu_pend) begin
         ldu_pend = 0;
      end else if (draining) begin
         if (done) draining = 0;
         else drain_left--;
      end else if (lu) begin
         ldu_pend = 1;
      end else if (cs) begin
         draining = 1; drain_left = DRAIN_MAX - 1;
      end
   endtask

   // Called at a negedge with inputs already applied; returns at the next negedge.
   task automatic cycle();
      #1;
      model_out();
      o_sfd = stall_fd; o_sde = stall_de; o_bub = bubble_de;
      o_fl = flush_fd; o_f1 = fwd_sel1; o_f2 = fwd_sel2;
      chk("stall_fd", o_sfd, e_sfd);
      chk("stall_de", o_sde, e_sde);
      chk("bubble_de", o_bub, e_bub);
      chk("flush_fd", o_fl, e_fl);
      chk("fwd_sel1", o_f1, e_f1);
      chk("fwd_sel2", o_f2, e_f2);
      @(posedge clk);
      model_adv();
      @(negedge clk);
   endtask

   task automatic set_dec(input bit v, input int rs1, input int rs2, input int dep, input bit csr);
      dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_dep = 2'(dep); dec_is_csr = csr;
   endtask

   task automatic set_ex(input bit v, input int rs1, input int rs2, input int rd, input int src);
      ex_valid = v; ex_rs1 = 5'(rs1); ex_rs2 = 5'(rs2); ex_rd = 5'(rd); ex_wb_src = 3'(src);
   endtask

   task automatic idle();
      set_dec(0, 0, 0, 0, 0);
      set_ex(0, 0, 0, 0, 0);
      mem_wait = 0; branch_taken = 0;
   endtask

   task automatic fill(input int rd);
      for (int i = 0; i < 3; i++) begin
         set_ex(1, 0, 0, rd, 1);
         cycle();
      end
   endtask

   int n;

   initial begin
      model_rst();
      #1;
      chk("rst_stall_fd", stall_fd, 0);
      chk("rst_stall_de", stall_de, 0);
      chk("rst_bubble_de", bubble_de, 0);
      chk("rst_flush_fd", flush_fd, 0);
      chk("rst_fwd_sel1", fwd_sel1, 0);
      chk("rst_fwd_sel2", fwd_sel2, 0);
      @(negedge clk);
      nrst = 1'b1;

      // load-use: stall one cycle, then consumer forwards from W
      idle();
      set_ex(1, 0, 0, 5, 2); set_dec(1, 5, 0, 1, 0);
      cycle();
      chk("lu_n_stall", o_sfd, 1);
      chk("lu_n_bubble", o_bub, 1);
      set_ex(0, 0, 0, 0, 0);
      cycle();
      chk("lu_n1_stall", o_sfd, 0);
      set_dec(0, 0, 0, 0, 0); set_ex(1, 5, 0, 6, 1);
      cycle();
      chk("lu_n2_fwd1", o_f1, 2);

      // forwarding priority M over W, and rd 0 never forwards
      idle();
      set_ex(1, 0, 0, 7, 1); cycle(); cycle();
      set_ex(0, 0, 7, 0, 0);
      #1; chk("fwd_prio_m", fwd_sel2, 1);
      @(negedge clk);
      set_ex(1, 0, 0, 0, 1); cycle(); cycle();
      set_ex(0, 0, 0, 0, 0);
      cycle();
      chk("fwd_rd0", o_f2, 0);

      // CSR drain with a full pipe
      idle(); fill(1);
      set_dec(1, 0, 0, 0, 1); set_ex(1, 0, 0, 1, 1);
      cycle();
      n = o_sfd;
      set_ex(0, 0, 0, 0, 0);
      for (int i = 0; i < 8 && o_sfd == 1; i++) begin
         cycle();
         if (o_sfd == 1) n++;
      end
      chk("csr_full_stalls", n, 3);

      // CSR with an empty pipe
      idle(); cycle(); cycle(); cycle();
      set_dec(1, 0, 0, 0, 1);
      cycle();
      chk("csr_empty_stall", o_sfd, 0);

      // mem freeze during drain holds scoreboard and remaining count
      idle(); fill(3);
      set_dec(1, 0, 0, 0, 1); set_ex(1, 0, 0, 3, 1);
      cycle();
      set_ex(0, 3, 0, 0, 0);
      cycle();
      mem_wait = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("frz_stall_de", o_sde, 1);
         chk("frz_bubble", o_bub, 0);
         chk("frz_fwd_held", o_f1, 2);
      end
      mem_wait = 0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (o_sfd == 0) break;
         n++;
      end
      chk("frz_resume_stalls", n, 1);

      // branch beats load-use, no LDUSE cycle follows
      idle();
      set_ex(1, 0, 0, 5, 2); set_dec(1, 0, 5, 2, 0); branch_taken = 1;
      cycle();
      chk("br_flush", o_fl, 1);
      chk("br_bubble", o_bub, 1);
      chk("br_no_stall", o_sfd, 0);
      branch_taken = 0;
      cycle();
      chk("br_then_run_lu", o_sfd, 1);
      set_ex(0, 0, 0, 0, 0);
      cycle();

      // async reset mid drain
      idle(); fill(4);
      set_dec(1, 0, 0, 0, 1); set_ex(1, 0, 0, 4, 1);
      cycle();
      set_ex(0, 4, 4, 0, 0);
      #1; chk("ar_pre_stall", stall_fd, 1);
      #1; nrst = 1'b0;
      #1;
      chk("ar_stall_fd", stall_fd, 0);
      chk("ar_bubble_de", bubble_de, 0);
      chk("ar_stall_de", stall_de, 0);
      chk("ar_flush_fd", flush_fd, 0);
      chk("ar_fwd_sel1", fwd_sel1, 0);
      model_rst();
      @(negedge clk);
      nrst = 1'b1;
      set_dec(0, 0, 0, 0, 0);
      for (int rs = 0; rs < 32; rs++) begin
         ex_rs1 = 5'(rs); ex_rs2 = 5'(31 - rs);
         #0.1;
         chk("ar_fwd1_zero", fwd_sel1, 0);
         chk("ar_fwd2_zero", fwd_sel2, 0);
      end
      @(posedge clk); model_adv(); @(negedge clk);
      set_ex(1, 0, 0, 9, 2); set_dec(1, 9, 0, 1, 0);
      cycle();
      chk("ar_run_lu", o_sfd, 1);
      set_ex(0, 0, 0, 0, 0);
      cycle();

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         set_dec($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3) == 0);
         set_ex($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4));
         mem_wait     = $urandom_range(0, 9) == 0;
         branch_taken = $urandom_range(0, 11) == 0;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
